// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the burst RAM controller slice.
// Holds default widths, the controller state encoding and the read-issue throttle.
// Imported by the interface, the read FIFO and the controller top.
package ram_ctrl_pkg;

  localparam int DW = 8;
  localparam int AW = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // A new read may be issued only if, after this cycle's pop, the FIFO plus the
  // beat still coming back from the RAM leaves a free slot for it.
  function automatic logic fifo_has_room(input logic [1:0] count,
                                         input logic       inflight,
                                         input logic       pop);
    logic [2:0] occ;
    logic [2:0] lim;
    occ = {1'b0, count} + {2'b00, inflight};
    lim = 3'd2 + {2'b00, pop};
    return (occ < lim);
  endfunction

endpackage

// File: rtl/ram_burst_ctrl_if.sv
// Client-side streams of the burst controller: command, write beats, read beats.
// master = client datapath, slave = controller.
// All three streams use valid/ready handshakes.
interface ram_burst_ctrl_if
  import ram_ctrl_pkg::*;
#(
  parameter int P_DW = ram_ctrl_pkg::DW,
  parameter int P_AW = ram_ctrl_pkg::AW
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_write;
  logic [P_AW-1:0] cmd_addr;
  logic [P_AW-1:0] cmd_len;
  logic            wr_valid;
  logic            wr_ready;
  logic [P_DW-1:0] wr_data;
  logic            rd_valid;
  logic            rd_ready;
  logic [P_DW-1:0] rd_data;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/rd_skid_fifo.sv
// Two-entry synchronous FIFO buffering RAM read data ahead of the read stream.
// Latency: a push is visible at the head the following cycle.
// Push and pop in the same cycle are both honoured; the caller never pushes when full.
module rd_skid_fifo
  import ram_ctrl_pkg::*;
#(
  parameter int P_DW = ram_ctrl_pkg::DW
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_push,
  input  logic [P_DW-1:0] i_push_dat,
  input  logic            i_pop,
  output logic [1:0]      o_count,
  output logic [P_DW-1:0] o_head
);
  logic [P_DW-1:0] r_mem [2];
  logic            r_wptr;
  logic            r_rptr;
  logic [1:0]      r_count;

  // Pointer and occupancy tracking; reset flushes the contents.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) r_wptr <= ~r_wptr;
      if (i_pop)  r_rptr <= ~r_rptr;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wptr] <= i_push_dat;
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst initiator for a single-port RAM with registered read data.
// Latency: writes hit the RAM in the beat cycle; read data appears 3 cycles after the command.
// Backpressure: write stalls on wr_valid gaps; read issues throttle so the 2-entry FIFO never overflows.
module ram_burst_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int P_DW = ram_ctrl_pkg::DW,
  parameter int P_AW = ram_ctrl_pkg::AW
) (
  input  logic              i_clk,
  input  logic              i_rst,
  ram_burst_ctrl_if.slave   bus,
  output logic              o_busy,
  output logic              o_done,
  output logic [P_AW-1:0]   o_ram_addr,
  output logic [P_DW-1:0]   o_ram_din,
  output logic              o_ram_we,
  input  logic [P_DW-1:0]   i_ram_dout
);
  localparam logic [P_AW-1:0] L_ONE  = P_AW'(1);
  localparam logic [P_AW-1:0] L_ZERO = '0;

  state_t          r_state;
  logic [P_AW-1:0] r_addr;
  logic [P_AW-1:0] r_cnt;
  logic            r_inflight;
  logic            r_done;

  logic [1:0]      w_fifo_count;
  logic [P_DW-1:0] w_fifo_head;
  logic            w_rd_valid;
  logic            w_pop;
  logic            w_issue;
  logic            w_wr_beat;

  assign w_rd_valid = (w_fifo_count != 2'd0);
  assign w_pop      = w_rd_valid & bus.rd_ready;
  assign w_wr_beat  = (r_state == WRITE) & bus.wr_valid;
  assign w_issue    = (r_state == READ) & fifo_has_room(w_fifo_count, r_inflight, w_pop);

  // Burst sequencing: command capture, per-beat address/count stepping and completion pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_addr     <= L_ZERO;
      r_cnt      <= L_ZERO;
      r_inflight <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_issue;
      case (r_state)
        IDLE: begin
          if (bus.cmd_valid) begin
            r_addr  <= bus.cmd_addr;
            r_cnt   <= bus.cmd_len;
            r_state <= bus.cmd_write ? WRITE : READ;
          end
        end
        WRITE: begin
          if (bus.wr_valid) begin
            r_addr <= r_addr + L_ONE;
            r_cnt  <= r_cnt - L_ONE;
            if (r_cnt == L_ZERO) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        READ: begin
          if (w_issue) begin
            r_addr <= r_addr + L_ONE;
            r_cnt  <= r_cnt - L_ONE;
            if (r_cnt == L_ZERO) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!r_inflight && (w_fifo_count == 2'd0)) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  rd_skid_fifo #(.P_DW(P_DW)) u_rd_fifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_push     (r_inflight),
    .i_push_dat (i_ram_dout),
    .i_pop      (w_pop),
    .o_count    (w_fifo_count),
    .o_head     (w_fifo_head)
  );

  assign bus.cmd_ready = (r_state == IDLE);
  assign bus.wr_ready  = (r_state == WRITE);
  assign bus.rd_valid  = w_rd_valid;
  assign bus.rd_data   = w_fifo_head;

  assign o_busy     = (r_state != IDLE);
  assign o_done     = r_done;
  assign o_ram_addr = r_addr;
  assign o_ram_din  = bus.wr_data;
  assign o_ram_we   = w_wr_beat;

endmodule
